// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with a valid qualifier, a registered match
// pulse and a saturating match counter with synchronous clear.
module seq_detector_param #(
    parameter int             LEN     = 5,
    parameter logic [LEN-1:0] PATTERN = 5'b00110,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in,
    input  logic             clr_count,
    output logic             out,
    output logic [CNT_W-1:0] match_count,
    output logic [5:0]       fill
);

    localparam logic [5:0]       FILL_MAX = 6'(LEN);
    localparam logic [5:0]       FILL_HIT = 6'(LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [LEN-1:0]   hist_q, hist_d;
    logic [5:0]       fill_q, fill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q;
    logic             match;

    always_comb begin
        hist_d = {hist_q[LEN-2:0], in};
        // fill_q counts bits already held; the current bit makes it LEN
        match  = en && (hist_d == PATTERN) && (fill_q >= FILL_HIT);

        fill_d = fill_q;
        if (en) begin
            if (match && !OVERLAP) begin
                fill_d = '0;
            end else if (fill_q < FILL_MAX) begin
                fill_d = fill_q + 6'd1;
            end
        end

        cnt_d = cnt_q;
        if (clr_count) begin
            cnt_d = '0;
        end else if (match && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
            out_q  <= 1'b0;
        end else begin
            if (en) begin
                hist_q <= hist_d;
            end
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
            out_q  <= match;
        end
    end

    assign out         = out_q;
    assign match_count = cnt_q;
    assign fill        = fill_q;

endmodule
